// File: rtl/mpu_pkg.sv
// Shared types and constants for the MPU6050 shake detector: FSM encoding,
// frame geometry, byte order and the per-axis absolute-difference helper.
package mpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_COMPUTE = 2'd2
  } state_t;

  localparam int FRAME_BYTES = 6;
  localparam int AXIS_W      = 16;
  localparam int METRIC_W    = 19;
  localparam int MAG_W       = AXIS_W + 1;
  localparam int NUM_AXES    = 3;

  localparam int IDX_AX_H = 0;
  localparam int IDX_AX_L = 1;
  localparam int IDX_AY_H = 2;
  localparam int IDX_AY_L = 3;
  localparam int IDX_AZ_H = 4;
  localparam int IDX_AZ_L = 5;

  // |a - b| with a 17-bit intermediate so no 16-bit pair can overflow
  function automatic logic [MAG_W-1:0] abs_diff(input logic signed [AXIS_W-1:0] a,
                                                 input logic signed [AXIS_W-1:0] b);
    logic signed [MAG_W-1:0] d;
    logic        [MAG_W-1:0] m;
    d = {a[AXIS_W-1], a} - {b[AXIS_W-1], b};
    m = d[MAG_W-1] ? -d : d;
    return m;
  endfunction

endpackage

// File: rtl/mpu_frame_assembler.sv
// Turns the I2C master's byte stream into a 48-bit big-endian frame:
// rising-edge byte capture, byte index, frame register and timeout counter.
module mpu_frame_assembler
  import mpu_pkg::*;
#(
  parameter int TIMEOUT = 400000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid,
  input  logic                     collect,
  input  logic                     clear,
  output logic [8*FRAME_BYTES-1:0] frame,
  output logic                     frame_done,
  output logic                     frame_err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic                     valid_d1_reg;
  logic                     valid_d2_reg;
  logic [7:0]               data_d1_reg;
  logic [2:0]               idx_reg;
  logic [TW-1:0]            tmo_reg;
  logic [8*FRAME_BYTES-1:0] frame_reg;
  logic [8*FRAME_BYTES-1:0] frame_next;
  logic                     accept;
  logic                     tmo_hit;

  assign accept     = collect && valid_d1_reg && !valid_d2_reg;
  assign frame_done = accept && (idx_reg == 3'(IDX_AZ_L));
  assign tmo_hit    = (tmo_reg == TW'(TIMEOUT - 1));
  // A frame completing on the timeout cycle still counts as a good frame
  assign frame_err  = collect && tmo_hit && !frame_done;

  // The byte landing this cycle is merged so the top sees the full frame at once
  generate
    for (genvar gi = 0; gi < FRAME_BYTES; gi++) begin : g_byte
      localparam int HI = 8 * (FRAME_BYTES - gi) - 1;
      assign frame_next[HI -: 8] = (accept && idx_reg == 3'(gi)) ? data_d1_reg
                                                                 : frame_reg[HI -: 8];
    end
  endgenerate

  assign frame = frame_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_d1_reg <= 1'b0;
      valid_d2_reg <= 1'b0;
      data_d1_reg  <= '0;
      idx_reg      <= '0;
      tmo_reg      <= '0;
      frame_reg    <= '0;
    end else begin
      valid_d1_reg <= byte_valid;
      valid_d2_reg <= valid_d1_reg;
      data_d1_reg  <= byte_in;
      frame_reg    <= frame_next;
      if (clear) begin
        idx_reg <= '0;
        tmo_reg <= '0;
      end else if (collect) begin
        if (accept)   idx_reg <= idx_reg + 3'd1;
        if (!tmo_hit) tmo_reg <= tmo_reg + TW'(1);
      end
    end
  end

endmodule

// File: rtl/mpu_shake_detector.sv
// Polls the MPU6050 master, assembles XYZ samples and fires a debounced shake event.
// Build option MPU_SHAKE_IIR_EN: per-axis IIR baseline instead of previous sample.
module mpu_shake_detector
  import mpu_pkg::*;
#(
  parameter int POLL_DIV        = 500000,
  parameter int TIMEOUT         = 400000,
  parameter int THRESH          = 12000,
  parameter int HOLD_SAMPLES    = 3,
  parameter int REFRACT_SAMPLES = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid,
  output logic                     start,
  output logic signed [AXIS_W-1:0] ax,
  output logic signed [AXIS_W-1:0] ay,
  output logic signed [AXIS_W-1:0] az,
  output logic                     sample_valid,
  output logic                     shake,
  output logic                     frame_err,
  output logic [15:0]              shake_cnt
);

  localparam int PW = $clog2(POLL_DIV);

  state_t                     state_reg, state_next;
  logic [PW-1:0]              poll_reg;
  logic                       wrap;
  logic [8*FRAME_BYTES-1:0]   frame;
  logic                       frame_done;
  logic signed [AXIS_W-1:0]   cur      [NUM_AXES];
  logic signed [AXIS_W-1:0]   ref_reg  [NUM_AXES];
  logic signed [AXIS_W-1:0]   ref_next [NUM_AXES];
  logic [MAG_W-1:0]           mag      [NUM_AXES];
  logic [METRIC_W-1:0]        metric;
  logic                       over;
  logic                       primed_reg;
  logic [3:0]                 hold_reg;
  logic [7:0]                 refract_reg;
  logic signed [AXIS_W-1:0]   ax_reg, ay_reg, az_reg;
  logic                       sample_valid_reg, shake_reg;
  logic [15:0]                shake_cnt_reg;

  assign wrap  = (poll_reg == PW'(POLL_DIV - 1));
  assign start = wrap && (state_reg == ST_IDLE);

  mpu_frame_assembler #(.TIMEOUT(TIMEOUT)) u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .collect    (state_reg == ST_COLLECT),
    .clear      (start),
    .frame      (frame),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  generate
    for (genvar gi = 0; gi < NUM_AXES; gi++) begin : g_axis
      assign cur[gi] = frame[8*FRAME_BYTES-1-2*AXIS_W/2*gi*2/2 -: AXIS_W];
      assign mag[gi] = abs_diff(cur[gi], ref_reg[gi]);
`ifdef MPU_SHAKE_IIR_EN
      logic signed [MAG_W-1:0] diff;
      logic signed [MAG_W-1:0] step;
      assign diff = {cur[gi][AXIS_W-1], cur[gi]} - {ref_reg[gi][AXIS_W-1], ref_reg[gi]};
      assign step = diff >>> 3;
      assign ref_next[gi] = primed_reg
                          ? AXIS_W'({ref_reg[gi][AXIS_W-1], ref_reg[gi]} + step)
                          : cur[gi];
`else
      assign ref_next[gi] = cur[gi];
`endif
    end
  endgenerate

  assign metric = METRIC_W'(mag[0]) + METRIC_W'(mag[1]) + METRIC_W'(mag[2]);
  assign over   = metric > METRIC_W'(THRESH);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (start) state_next = ST_COLLECT;
      ST_COLLECT: begin
        if (frame_done)     state_next = ST_COMPUTE;
        else if (frame_err) state_next = ST_IDLE;
      end
      ST_COMPUTE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Outputs register on the 6th-byte cycle so they appear together in COMPUTE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      poll_reg         <= '0;
      primed_reg       <= 1'b0;
      hold_reg         <= '0;
      refract_reg      <= '0;
      ax_reg           <= '0;
      ay_reg           <= '0;
      az_reg           <= '0;
      sample_valid_reg <= 1'b0;
      shake_reg        <= 1'b0;
      shake_cnt_reg    <= '0;
      for (int i = 0; i < NUM_AXES; i++) ref_reg[i] <= '0;
    end else begin
      state_reg        <= state_next;
      poll_reg         <= wrap ? '0 : poll_reg + PW'(1);
      sample_valid_reg <= frame_done;
      shake_reg        <= 1'b0;
      if (frame_done) begin
        ax_reg     <= cur[0];
        ay_reg     <= cur[1];
        az_reg     <= cur[2];
        primed_reg <= 1'b1;
        for (int i = 0; i < NUM_AXES; i++) ref_reg[i] <= ref_next[i];
        if (primed_reg) begin
          if (refract_reg != 8'd0) begin
            refract_reg <= refract_reg - 8'd1;
            hold_reg    <= '0;
          end else if (over) begin
            if (hold_reg == 4'(HOLD_SAMPLES - 1)) begin
              shake_reg   <= 1'b1;
              hold_reg    <= '0;
              refract_reg <= 8'(REFRACT_SAMPLES);
              if (shake_cnt_reg != 16'hFFFF) shake_cnt_reg <= shake_cnt_reg + 16'd1;
            end else begin
              hold_reg <= hold_reg + 4'd1;
            end
          end else begin
            hold_reg <= '0;
          end
        end
      end
    end
  end

  assign ax           = ax_reg;
  assign ay           = ay_reg;
  assign az           = az_reg;
  assign sample_valid = sample_valid_reg;
  assign shake        = shake_reg;
  assign shake_cnt    = shake_cnt_reg;

endmodule

// File: tb/tb_mpu_shake_detector.sv
// Scoreboard bench for mpu_shake_detector: random frames, timeouts and resets
// checked against an arithmetic model of the shake rules.
module tb_mpu_shake_detector;

  localparam int POLL_DIV = 100;
  localparam int TIMEOUT  = 50;
  localparam int THRESH   = 12000;
  localparam int HOLD     = 3;
  localparam int REFRACT  = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        start;
  logic [15:0] ax, ay, az;
  logic        sample_valid, shake, frame_err;
  logic [15:0] shake_cnt;

  always #5 clk = ~clk;

  mpu_shake_detector #(
    .POLL_DIV(POLL_DIV), .TIMEOUT(TIMEOUT), .THRESH(THRESH),
    .HOLD_SAMPLES(HOLD), .REFRACT_SAMPLES(REFRACT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
    .start(start), .ax(ax), .ay(ay), .az(az), .sample_valid(sample_valid),
    .shake(shake), .frame_err(frame_err), .shake_cnt(shake_cnt)
  );

  typedef struct {
    logic [15:0] ax, ay, az;
    logic        shake;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t err_q[$];
  int checks = 0;
  int passed = 0;
  int cyc;
  int last_start = 0;

  int m_primed, m_hold, m_refract, m_cnt;
  int m_rx, m_ry, m_rz;
  logic [15:0] m_ax, m_ay, m_az;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, req, req, cyc);
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    m_primed = 0; m_hold = 0; m_refract = 0; m_cnt = 0;
    m_rx = 0; m_ry = 0; m_rz = 0;
    m_ax = '0; m_ay = '0; m_az = '0;
  endtask

  task automatic model_frame(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    exp_t e;
    int cx, cy, cz, d;
    cx = int'($signed(x)); cy = int'($signed(y)); cz = int'($signed(z));
    e.shake = 1'b0;
    if (m_primed == 0) begin
      m_primed = 1;
      m_rx = cx; m_ry = cy; m_rz = cz;
    end else begin
      d = iabs(cx - m_rx) + iabs(cy - m_ry) + iabs(cz - m_rz);
      if (m_refract > 0) begin
        m_refract--;
        m_hold = 0;
      end else if (d > THRESH) begin
        m_hold++;
        if (m_hold == HOLD) begin
          e.shake = 1'b1;
          m_hold = 0;
          m_refract = REFRACT;
          if (m_cnt < 65535) m_cnt++;
        end
      end else begin
        m_hold = 0;
      end
`ifdef MPU_SHAKE_IIR_EN
      m_rx = m_rx + ((cx - m_rx) >>> 3);
      m_ry = m_ry + ((cy - m_ry) >>> 3);
      m_rz = m_rz + ((cz - m_rz) >>> 3);
`else
      m_rx = cx; m_ry = cy; m_rz = cz;
`endif
    end
    m_ax = x; m_ay = y; m_az = z;
    e.ax = x; e.ay = y; e.az = z;
    e.cnt = 16'(m_cnt);
    exp_q.push_back(e);
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  // Monitor: pops expectations whenever the DUT presents a sample or an error
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      if (start) begin
        check("start_phase", cyc % POLL_DIV, POLL_DIV - 1);
        last_start = cyc;
      end
      if (sample_valid) begin
        check("sample_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("ax", int'(ax), int'(e.ax));
          check("ay", int'(ay), int'(e.ay));
          check("az", int'(az), int'(e.az));
          check("shake", int'(shake), int'(e.shake));
          check("shake_cnt", int'(shake_cnt), int'(e.cnt));
          $display("sample ax=%0d ay=%0d az=%0d shake=%0d cnt=%0d", $signed(ax),
                   $signed(ay), $signed(az), shake, shake_cnt);
        end
      end else if (shake) begin
        check("shake_alone", int'(shake), 0);
      end
      if (frame_err) begin
        check("err_expected", int'(err_q.size() > 0), 1);
        if (err_q.size() > 0) begin
          e = err_q.pop_front();
          check("err_latency", cyc - last_start, TIMEOUT);
          check("err_ax_kept", int'(ax), int'(e.ax));
          check("err_ay_kept", int'(ay), int'(e.ay));
          check("err_az_kept", int'(az), int'(e.az));
          $display("frame_err at %0d cycles after start", cyc - last_start);
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_start"}, int'(start), 0);
    check({tag, "_ax"}, int'(ax), 0);
    check({tag, "_ay"}, int'(ay), 0);
    check({tag, "_az"}, int'(az), 0);
    check({tag, "_sv"}, int'(sample_valid), 0);
    check({tag, "_shake"}, int'(shake), 0);
    check({tag, "_ferr"}, int'(frame_err), 0);
    check({tag, "_cnt"}, int'(shake_cnt), 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int h);
    byte_in = b;
    byte_valid = 1'b1;
    repeat (h) @(negedge clk);
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_start();
    int n = 0;
    while (!start && n < 4 * POLL_DIV) begin
      @(negedge clk);
      n++;
    end
    check("start_seen", int'(start), 1);
    @(negedge clk);
  endtask

  task automatic run_frame(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                           input int nbytes, input int hmax);
    logic [7:0] b [6];
    exp_t e;
    b[0] = x[15:8]; b[1] = x[7:0]; b[2] = y[15:8];
    b[3] = y[7:0];  b[4] = z[15:8]; b[5] = z[7:0];
    wait_start();
    if (nbytes == 6) begin
      model_frame(x, y, z);
    end else begin
      e.ax = m_ax; e.ay = m_ay; e.az = m_az; e.shake = 1'b0; e.cnt = 16'(m_cnt);
      err_q.push_back(e);
    end
    for (int i = 0; i < nbytes; i++) send_byte(b[i], $urandom_range(hmax, 1));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] v;
    model_reset();
    rst_n = 1'b0;
    byte_valid = 1'b0;
    byte_in = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check_zero("idle");

    run_frame(16'h1234, 16'hFFFE, 16'h4000, 6, 1);
    run_frame(16'h7777, 16'h1111, 16'h2222, 4, 1);
    run_frame(16'h0BAD, 16'hF00D, 16'h0042, 6, 1);
    for (int k = 0; k < 3; k++)
      run_frame(16'($urandom), 16'($urandom), 16'($urandom), 6, 5);

    repeat (5) run_frame(16'hFFFF, 16'hFFFF, 16'hFFFF, 6, 5);
    v = 16'hFFFF;
    check("pre_reset_ax", int'(ax), int'(v));

    wait_start();
    for (int i = 0; i < 3; i++) send_byte(8'hA5, 1);
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 30; k++)
      run_frame((k % 2 == 0) ? 16'd8000 : -16'sd8000, 16'd300, 16'd16000, 6, 5);
    check("alt_shake_cnt", int'(shake_cnt), 2);

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++)
      run_frame((k % 2 == 0) ? 16'd0 : 16'd12000, -16'sd50, 16'd7, 6, 2);
    check("eq_no_shake", int'(shake_cnt), 0);
    for (int k = 0; k < 10; k++)
      run_frame((k % 2 == 0) ? 16'd0 : 16'(12000 + $urandom_range(1, 0)),
                -16'sd50, 16'd7, 6, 2);

    for (int k = 0; k < 15; k++)
      run_frame(16'($urandom), 16'($urandom), 16'($urandom),
                ($urandom_range(4, 0) == 0) ? $urandom_range(5, 3) : 6, 5);

    repeat (POLL_DIV) @(negedge clk);
    check("sample_queue_empty", exp_q.size(), 0);
    check("err_queue_empty", err_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mpu_shake_detector.md
Name: mpu_shake_detector

Overview:
Downstream consumer of the MPU6050 I2C master's byte stream. It issues periodic poll `start` pulses to the master and assembles 6 returned bytes (AX_H, AX_L, AY_H, AY_L, AZ_H, AZ_L) into signed 16-bit axis samples. It computes a per-sample activity metric and raises a one-cycle `shake` event for the tamagotchi game logic after sustained motion, with refractory hold-off.

Parameters:
POLL_DIV, 500000, clk cycles between poll `start` pulses (10 ms at 50 MHz); must be ≥ 2.
TIMEOUT, 400000, clk cycles allowed after `start` for all 6 bytes before the frame is dropped.
THRESH, 12000, activity threshold; unsigned, compared against a 19-bit sum.
HOLD_SAMPLES, 3, consecutive over-threshold samples needed to fire `shake` (1..15).
REFRACT_SAMPLES, 20, samples ignored after a `shake` (0..255).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
byte_in  in  8  byte from I2C master (its data_out)
byte_valid  in  1  level/pulse from I2C master (its data_valid); rising edge = new byte
start  out  1  one-cycle poll request to I2C master
ax  out  16  signed X sample, last complete frame
ay  out  16  signed Y sample
az  out  16  signed Z sample
sample_valid  out  1  one-cycle pulse when ax/ay/az update
shake  out  1  one-cycle shake event
frame_err  out  1  one-cycle pulse on frame timeout
shake_cnt  out  16  saturating count of shake events

Behaviour:
- Reset is asynchronous, active-low. All outputs are 0 during reset; internal counters, byte index, primed flag, hold and refractory counters are also cleared.
- Byte capture: `byte_valid` is registered. A byte is accepted only on a 0→1 transition, so a level held high for N cycles counts once.
- Poll timer: free-running 0..POLL_DIV-1. `start` pulses for one cycle at wrap, but only in state IDLE. A wrap in any other state is skipped, not queued.
- FSM states:
  - IDLE: on `start` → COLLECT, byte index := 0, timeout counter := 0.
  - COLLECT: each accepted byte is stored at byte index, big-endian per axis; index increments. On the 6th byte → COMPUTE. If timeout counter reaches TIMEOUT-1 first → `frame_err` pulse, partial bytes discarded, outputs unchanged → IDLE.
  - COMPUTE: one cycle. Loads ax/ay/az, pulses `sample_valid` the cycle after the 6th byte edge is detected, evaluates the metric → IDLE.
- Bytes arriving in IDLE or COMPUTE are ignored.
- Metric: d = |cur_x−ref_x| + |cur_y−ref_y| + |cur_z−ref_z|.
  - Each difference is sign-extended to 17 bits and the absolute value taken; the sum is 19-bit unsigned, so there is no overflow.
  - ref is the previous sample (non-IIR build).
- First frame after reset: primed := 1, ref loaded, no comparison.
- Hold counter: increments when d > THRESH (strict), clears otherwise.
  - Reaching HOLD_SAMPLES → `shake` pulse (same cycle as `sample_valid`), hold := 0, refract := REFRACT_SAMPLES, shake_cnt += 1, saturating at 0xFFFF.
- While refract > 0: each sample decrements refract, hold stays 0, and no shake fires. ref still updates.
- `frame_err` does not affect hold, refract or ref.
- Reset mid-frame: everything clears; the next frame is treated as first (unprimed).

Optional Feature:
MPU_SHAKE_IIR_EN
- Defined: ref is an IIR baseline per axis, ref += (cur − ref) >>> 3, arithmetic shift, 17-bit intermediate. The first frame loads ref = cur.
- Undefined: ref = previous sample. Ports are identical in both builds.

Decomposition:
- Package mpu_pkg holds:
  - FSM state encoding (IDLE, COLLECT, COMPUTE) as a 2-bit typedef
  - FRAME_BYTES = 6
  - AXIS_W = 16, METRIC_W = 19
  - byte index order constants
- One sub-module: mpu_frame_assembler, covering edge detection, byte index, the 48-bit frame register and the timeout counter. It outputs frame_done and frame_err. The metric, hold and refractory logic stays in the top level.

Test Plan:
- Reset release, POLL_DIV=100: `start` fires at cycle 99, then every 100 cycles while frames complete. All outputs are 0 before the first frame.
- Byte stream 0x12,0x34,0xFF,0xFE,0x40,0x00 → ax=0x1234, ay=−2, az=0x4000, single `sample_valid`, no `shake` (unprimed).
- Frames alternating ax=+8000/−8000 with ay and az constant, THRESH=12000, HOLD=3:
  - d=16000 from the 2nd frame onward
  - `shake` fires on the 4th frame, shake_cnt=1
  - no further `shake` for 20 frames (REFRACT=20)
- `byte_valid` held high 5 cycles per byte → each counted once; 6 bytes produce exactly one frame.
- Only 4 bytes delivered, TIMEOUT=50 → `frame_err` at cycle 50 after `start`, ax/ay/az unchanged, next poll assembles cleanly.
- Metric exactly equal to THRESH (d=12000) → hold does not increment. Reset asserted mid-COLLECT → outputs 0 immediately (asynchronous).
